node_index_allocator: RTL and testbench
=======================================

# node_index_allocator

Parametrised successor of the day-11 string-to-index mapper. It assigns dense, first-seen node indices to fixed-width node name strings and can resolve a source and a destination name in the same beat. It adds valid/ready backpressure, table-capacity overflow detection, and an internal table-clear sweep so it can be restarted between puzzle inputs. It sits between the line decoder and the graph/edge storage.

## Interface
- NODE_STR_WIDTH, 15, encoded node name width; LUT depth is 2**NODE_STR_WIDTH (override allowed for test only)
- MAX_NODES, 1024, index capacity
- NODE_IDX_WIDTH, $clog2(MAX_NODES), index width
- clk  in  1  clock; all logic rises on posedge
- rst_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous restart request, single-cycle pulse
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_last  in  1  final beat of the input (decoding done)
- in_src_en  in  1  src_str present in this beat
- in_dst_en  in  1  dst_str present in this beat
- in_src_str  in  NODE_STR_WIDTH  source name
- in_dst_str  in  NODE_STR_WIDTH  destination name
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts the result
- out_last, out_src_en, out_dst_en  out  1 each  copies of the inputs
- out_src_idx, out_dst_idx  out  NODE_IDX_WIDTH  resolved indices
- out_overflow  out  1  this beat needed an index beyond capacity
- node_cnt  out  NODE_IDX_WIDTH+1  number of indices allocated so far
- overflow  out  1  sticky; set if any allocation was refused
- init_busy  out  1  table clear sweep in progress

## Operation
- The FSM has three states: INIT, RUN and DONE.
  - INIT clears one LUT entry per cycle (assigned bit = 0), using a sweep address from 0 to 2**NODE_STR_WIDTH-1. After the last address it moves to RUN. in_ready=0 and init_busy=1 throughout INIT.
  - In RUN, a beat is accepted on in_valid && in_ready. If the accepted beat has in_last=1, the FSM moves to DONE.
  - In DONE, in_ready=0. The outputs drain normally.
  - clear in RUN or DONE moves the FSM to INIT. It also zeroes node_cnt and overflow, drops any pending out_valid, and restarts the sweep at 0. clear during INIT restarts the sweep.
- Lookup on an accepted beat:
  - Source: if the entry is assigned, use the stored index. Otherwise allocate node_cnt.
  - Destination: if the entry is assigned, use the stored index.
  - Destination, same string as the source (in_dst_str == in_src_str): reuse the source result. Only one allocation is made.
  - Destination, otherwise unassigned: allocate node_cnt + (1 if the source allocated).
  - Allocations write {1, idx} to the LUT. node_cnt advances by 0, 1 or 2.
- Disabled halves (en=0) never read, allocate or write. Their idx output is 0.
- Capacity: any allocation whose index would be >= MAX_NODES is refused.
  - The LUT is not written for it.
  - Its idx output is all-ones.
  - out_overflow=1 and overflow is set.
  - node_cnt saturates at MAX_NODES.
- Source and destination are applied in the same cycle. Unlike the previous mapper, which required a separate src beat, no exclusivity is required.

## Timing
- Reset values: state INIT, sweep address 0, in_ready 0, init_busy 1, out_valid 0, all out_* 0, node_cnt 0, overflow 0.
- INIT lasts exactly 2**NODE_STR_WIDTH cycles after rst_n deasserts or after clear.
- Latency is 1 cycle: a beat accepted at edge N presents out_valid and the results after edge N.
- The LUT write happens at the acceptance edge, so a back-to-back beat sees the previous allocations. No forwarding is needed.
- in_ready = (state==RUN) && (!out_valid || out_ready). Sustained throughput is one beat per cycle.
- The output register holds its contents while out_valid && !out_ready.
- rst_n assertion mid-beat discards all state. The LUT contents are then invalid until the sweep completes.

## Structure
- Package node_map_pkg holds:
  - node_str_t and node_idx_t
  - lut_entry_t, a packed struct {assigned, index}
  - a state enum {INIT, RUN, DONE}
- Sub-module node_lut_ram holds the LUT:
  - a register array with two combinational read ports (src, dst)
  - two write ports, where src wins on an equal address (unreachable by construction)
  - a clear write port driven by the sweep
- The top level contains the FSM, the allocation arithmetic and the output register.

## Test plan
All tests use NODE_STR_WIDTH=6.
- Reset release: init_busy=1 for 64 cycles, then in_ready=1; node_cnt=0.
- Single-source beats with strings 5, 9, 5: idx 0, 1, 0; node_cnt=2.
- Dual beat src=3, dst=7, then src=7, dst=3: first beat (0,1), second beat (1,0); node_cnt=2.
- Dual beat src=dst=12: (0,0); node_cnt=1.
- MAX_NODES=4, 5 distinct strings: the 5th beat has out_overflow=1 and idx all-ones; overflow=1; node_cnt=4.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1. Then:
  - in_ready=0 and the output is stable.
  - Release out_ready: no beat is lost.
  - in_last produces out_last and DONE.
  - clear re-enters INIT and string 5 then maps to 0.

Source files
------------

// File: rtl/node_index_allocator_pkg.sv
// node_map_pkg: shared types for the node index allocator.
//   - default widths for the node name string and the node index
//   - lut_entry_t: one LUT word {assigned, index}
//   - state_t: allocator FSM states
//   - fits_capacity(): true when an index can still be handed out
package node_map_pkg;

  localparam int DEF_NODE_STR_WIDTH = 15;
  localparam int DEF_MAX_NODES      = 1024;
  localparam int DEF_NODE_IDX_WIDTH = $clog2(DEF_MAX_NODES);

  typedef logic [DEF_NODE_STR_WIDTH-1:0] node_str_t;
  typedef logic [DEF_NODE_IDX_WIDTH-1:0] node_idx_t;

  typedef struct packed {
    logic      assigned;
    node_idx_t index;
  } lut_entry_t;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // An index is only handed out while it stays below the capacity.
  function automatic logic fits_capacity(input int unsigned idx,
                                         input int unsigned max_nodes);
    return (idx < max_nodes);
  endfunction

endpackage

// File: rtl/node_index_allocator_if.sv
// node_index_allocator_if: request/result streams of the node index allocator.
//   in_*  : decoded line beat (valid/ready) carrying src/dst node names
//   out_* : resolved indices (valid/ready) towards the graph storage
//   master: producer of in_* and consumer of out_* (line decoder side)
//   slave : the allocator itself
interface node_index_allocator_if #(
  parameter int NODE_STR_WIDTH = 15,
  parameter int NODE_IDX_WIDTH = 10
);
  logic                      in_valid;
  logic                      in_ready;
  logic                      in_last;
  logic                      in_src_en;
  logic                      in_dst_en;
  logic [NODE_STR_WIDTH-1:0] in_src_str;
  logic [NODE_STR_WIDTH-1:0] in_dst_str;
  logic                      out_valid;
  logic                      out_ready;
  logic                      out_last;
  logic                      out_src_en;
  logic                      out_dst_en;
  logic [NODE_IDX_WIDTH-1:0] out_src_idx;
  logic [NODE_IDX_WIDTH-1:0] out_dst_idx;
  logic                      out_overflow;

  modport master (
    output in_valid, in_last, in_src_en, in_dst_en, in_src_str, in_dst_str, out_ready,
    input  in_ready, out_valid, out_last, out_src_en, out_dst_en,
           out_src_idx, out_dst_idx, out_overflow
  );

  modport slave (
    input  in_valid, in_last, in_src_en, in_dst_en, in_src_str, in_dst_str, out_ready,
    output in_ready, out_valid, out_last, out_src_en, out_dst_en,
           out_src_idx, out_dst_idx, out_overflow
  );
endinterface

// File: rtl/node_index_allocator_lut_ram.sv
// node_lut_ram: name -> {assigned, index} lookup table.
//   src_raddr/dst_raddr -> src_rdata/dst_rdata : combinational read ports
//   src_we/dst_we       : allocation writes (src wins on equal address)
//   clr_we/clr_addr     : sweep port, writes an all-zero entry; dominates
// The array has no reset; its contents are meaningless until a full
// sweep has cleared every entry.
module node_lut_ram #(
  parameter int STR_W = 15,
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic [STR_W-1:0] src_raddr,
  input  logic [STR_W-1:0] dst_raddr,
  output logic [IDX_W:0]   src_rdata,
  output logic [IDX_W:0]   dst_rdata,
  input  logic             src_we,
  input  logic [STR_W-1:0] src_waddr,
  input  logic [IDX_W:0]   src_wdata,
  input  logic             dst_we,
  input  logic [STR_W-1:0] dst_waddr,
  input  logic [IDX_W:0]   dst_wdata,
  input  logic             clr_we,
  input  logic [STR_W-1:0] clr_addr
);
  localparam int DEPTH = 2 ** STR_W;

  logic [IDX_W:0] mem_q [DEPTH];

  assign src_rdata = mem_q[src_raddr];
  assign dst_rdata = mem_q[dst_raddr];

  // Table write: sweep first, otherwise dst then src so src wins on a tie.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= {(IDX_W+1){1'b0}};
    end else begin
      if (dst_we) begin
        mem_q[dst_waddr] <= dst_wdata;
      end
      if (src_we) begin
        mem_q[src_waddr] <= src_wdata;
      end
    end
  end
endmodule

// File: rtl/node_index_allocator.sv
// node_index_allocator: dense first-seen index assignment for node names.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous restart (re-sweeps the table, zeroes counters)
//   bus        : slave side of node_index_allocator_if (in_* / out_* streams)
//   node_cnt   : indices allocated so far (saturates at MAX_NODES)
//   overflow   : sticky, some allocation was refused for lack of capacity
//   init_busy  : table clear sweep in progress
module node_index_allocator
  import node_map_pkg::*;
#(
  parameter int NODE_STR_WIDTH = DEF_NODE_STR_WIDTH,
  parameter int MAX_NODES      = DEF_MAX_NODES,
  parameter int NODE_IDX_WIDTH = $clog2(MAX_NODES)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  node_index_allocator_if.slave   bus,
  output logic [NODE_IDX_WIDTH:0] node_cnt,
  output logic                    overflow,
  output logic                    init_busy
);
  localparam int CNT_W = NODE_IDX_WIDTH + 1;
  localparam logic [NODE_STR_WIDTH-1:0] SWEEP_LAST = {NODE_STR_WIDTH{1'b1}};
  localparam logic [NODE_STR_WIDTH-1:0] SWEEP_ONE  = {{(NODE_STR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [NODE_IDX_WIDTH-1:0] IDX_ONES   = {NODE_IDX_WIDTH{1'b1}};
  localparam logic [NODE_IDX_WIDTH-1:0] IDX_ZERO   = {NODE_IDX_WIDTH{1'b0}};

  state_t                    state_q, state_d;
  logic [NODE_STR_WIDTH-1:0] sweep_q, sweep_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      ovf_q, ovf_d;
  logic                      out_valid_q, out_valid_d;
  logic                      out_last_q, out_last_d;
  logic                      out_src_en_q, out_src_en_d;
  logic                      out_dst_en_q, out_dst_en_d;
  logic [NODE_IDX_WIDTH-1:0] out_src_idx_q, out_src_idx_d;
  logic [NODE_IDX_WIDTH-1:0] out_dst_idx_q, out_dst_idx_d;
  logic                      out_ovf_q, out_ovf_d;

  logic [CNT_W-1:0]          src_rd, dst_rd;
  logic                      accept;
  logic                      src_need, src_ok, dst_need, dst_ok, same_str;
  logic [CNT_W-1:0]          dst_cand;
  logic [NODE_IDX_WIDTH-1:0] src_idx, dst_idx;
  logic                      beat_ovf;

  assign bus.in_ready = (state_q == RUN) && (!out_valid_q || bus.out_ready);
  // A clear in the same cycle as a handshake discards the beat.
  assign accept       = bus.in_valid && bus.in_ready && !clear;

  node_lut_ram #(
    .STR_W (NODE_STR_WIDTH),
    .IDX_W (NODE_IDX_WIDTH)
  ) u_lut (
    .clk       (clk),
    .src_raddr (bus.in_src_str),
    .dst_raddr (bus.in_dst_str),
    .src_rdata (src_rd),
    .dst_rdata (dst_rd),
    .src_we    (accept && src_ok),
    .src_waddr (bus.in_src_str),
    .src_wdata ({1'b1, src_idx}),
    .dst_we    (accept && dst_ok),
    .dst_waddr (bus.in_dst_str),
    .dst_wdata ({1'b1, dst_idx}),
    .clr_we    (state_q == INIT),
    .clr_addr  (sweep_q)
  );

  // Lookup/allocation for both halves of the current beat.
  always_comb begin
    src_need = bus.in_src_en && !src_rd[NODE_IDX_WIDTH];
    src_ok   = src_need && fits_capacity(32'(cnt_q), 32'(MAX_NODES));
    if (!bus.in_src_en) begin
      src_idx = IDX_ZERO;
    end else if (src_rd[NODE_IDX_WIDTH]) begin
      src_idx = src_rd[NODE_IDX_WIDTH-1:0];
    end else if (src_ok) begin
      src_idx = cnt_q[NODE_IDX_WIDTH-1:0];
    end else begin
      src_idx = IDX_ONES;
    end

    // Same name on both halves shares the source result: one allocation only.
    same_str = bus.in_src_en && bus.in_dst_en && (bus.in_dst_str == bus.in_src_str);
    dst_cand = cnt_q + {{(CNT_W-1){1'b0}}, src_ok};
    dst_need = bus.in_dst_en && !same_str && !dst_rd[NODE_IDX_WIDTH];
    dst_ok   = dst_need && fits_capacity(32'(dst_cand), 32'(MAX_NODES));
    if (!bus.in_dst_en) begin
      dst_idx = IDX_ZERO;
    end else if (same_str) begin
      dst_idx = src_idx;
    end else if (dst_rd[NODE_IDX_WIDTH]) begin
      dst_idx = dst_rd[NODE_IDX_WIDTH-1:0];
    end else if (dst_ok) begin
      dst_idx = dst_cand[NODE_IDX_WIDTH-1:0];
    end else begin
      dst_idx = IDX_ONES;
    end

    beat_ovf = (src_need && !src_ok) || (dst_need && !dst_ok);
  end

  // Next state: FSM, sweep, counters and the output register.
  always_comb begin
    state_d       = state_q;
    sweep_d       = sweep_q;
    cnt_d         = cnt_q;
    ovf_d         = ovf_q;
    out_valid_d   = out_valid_q;
    out_last_d    = out_last_q;
    out_src_en_d  = out_src_en_q;
    out_dst_en_d  = out_dst_en_q;
    out_src_idx_d = out_src_idx_q;
    out_dst_idx_d = out_dst_idx_q;
    out_ovf_d     = out_ovf_q;

    if (clear) begin
      state_d     = INIT;
      sweep_d     = {NODE_STR_WIDTH{1'b0}};
      cnt_d       = {CNT_W{1'b0}};
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          sweep_d = sweep_q + SWEEP_ONE;
          if (sweep_q == SWEEP_LAST) begin
            state_d = RUN;
          end else begin
            state_d = INIT;
          end
        end
        RUN: begin
          if (accept && bus.in_last) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = INIT;
        end
      endcase

      if (accept) begin
        cnt_d         = cnt_q + {{(CNT_W-1){1'b0}}, src_ok} + {{(CNT_W-1){1'b0}}, dst_ok};
        ovf_d         = ovf_q || beat_ovf;
        out_valid_d   = 1'b1;
        out_last_d    = bus.in_last;
        out_src_en_d  = bus.in_src_en;
        out_dst_en_d  = bus.in_dst_en;
        out_src_idx_d = src_idx;
        out_dst_idx_d = dst_idx;
        out_ovf_d     = beat_ovf;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= INIT;
      sweep_q       <= {NODE_STR_WIDTH{1'b0}};
      cnt_q         <= {CNT_W{1'b0}};
      ovf_q         <= 1'b0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      out_src_en_q  <= 1'b0;
      out_dst_en_q  <= 1'b0;
      out_src_idx_q <= IDX_ZERO;
      out_dst_idx_q <= IDX_ZERO;
      out_ovf_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sweep_q       <= sweep_d;
      cnt_q         <= cnt_d;
      ovf_q         <= ovf_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      out_src_en_q  <= out_src_en_d;
      out_dst_en_q  <= out_dst_en_d;
      out_src_idx_q <= out_src_idx_d;
      out_dst_idx_q <= out_dst_idx_d;
      out_ovf_q     <= out_ovf_d;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_last     = out_last_q;
  assign bus.out_src_en   = out_src_en_q;
  assign bus.out_dst_en   = out_dst_en_q;
  assign bus.out_src_idx  = out_src_idx_q;
  assign bus.out_dst_idx  = out_dst_idx_q;
  assign bus.out_overflow = out_ovf_q;
  assign node_cnt         = cnt_q;
  assign overflow         = ovf_q;
  assign init_busy        = (state_q == INIT);
endmodule

// File: tb/tb_node_index_allocator.sv
// Testbench for node_index_allocator with a 64-entry table and capacity 4.
module tb_node_index_allocator;
  localparam int SW = 6;
  localparam int MN = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic [IW:0]   node_cnt;
  logic          overflow;
  logic          init_busy;

  node_index_allocator_if #(.NODE_STR_WIDTH(SW), .NODE_IDX_WIDTH(IW)) bus ();

  node_index_allocator #(
    .NODE_STR_WIDTH (SW),
    .MAX_NODES      (MN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .bus       (bus),
    .node_cnt  (node_cnt),
    .overflow  (overflow),
    .init_busy (init_busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit clr;
    bit s_en;
    bit d_en;
    int s;
    int d;
    int e_s;
    int e_d;
    bit e_bovf;
    int e_cnt;
    bit e_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input bit clr, input bit se, input bit de, input int s, input int d,
                     input int es, input int ed, input bit ebo, input int ec, input bit eo);
    vec_t v;
    v.clr = clr; v.s_en = se; v.d_en = de; v.s = s; v.d = d;
    v.e_s = es; v.e_d = ed; v.e_bovf = ebo; v.e_cnt = ec; v.e_ovf = eo;
    vecs.push_back(v);
  endtask

  // Counts negedges with init_busy high, starting at the current negedge.
  task automatic wait_init(input string name);
    int n;
    n = 0;
    while (init_busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    check(name, n, 64);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    wait_init("clear_init_len");
  endtask

  // Presents one beat and returns #1 after the accepting edge.
  task automatic send(input bit se, input bit de, input int s, input int d, input bit last);
    int n;
    @(negedge clk);
    bus.in_valid   = 1'b1;
    bus.in_src_en  = se;
    bus.in_dst_en  = de;
    bus.in_src_str = SW'(s);
    bus.in_dst_str = SW'(d);
    bus.in_last    = last;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_last    = 1'b0;
    bus.in_src_en  = 1'b0;
    bus.in_dst_en  = 1'b0;
    bus.in_src_str = '0;
    bus.in_dst_str = '0;
    bus.out_ready  = 1'b1;

    // clr, se, de, s, d -> src idx, dst idx, beat ovf, node_cnt, sticky ovf
    add(0, 1, 0,  5,  0,  0, 0, 0, 1, 0);
    add(0, 1, 0,  9,  0,  1, 0, 0, 2, 0);
    add(0, 1, 0,  5,  0,  0, 0, 0, 2, 0);
    add(0, 0, 0,  5,  9,  0, 0, 0, 2, 0);
    add(1, 1, 1,  3,  7,  0, 1, 0, 2, 0);
    add(0, 1, 1,  7,  3,  1, 0, 0, 2, 0);
    add(1, 1, 1, 12, 12,  0, 0, 0, 1, 0);
    add(1, 1, 0,  1,  0,  0, 0, 0, 1, 0);
    add(0, 1, 0,  2,  0,  1, 0, 0, 2, 0);
    add(0, 1, 0,  3,  0,  2, 0, 0, 3, 0);
    add(0, 1, 0,  4,  0,  3, 0, 0, 4, 0);
    add(0, 1, 0,  6,  0,  3, 0, 1, 4, 1);
    add(0, 1, 0,  2,  0,  1, 0, 0, 4, 1);
    add(1, 1, 0,  1,  0,  0, 0, 0, 1, 0);
    add(0, 1, 0,  2,  0,  1, 0, 0, 2, 0);
    add(0, 1, 0,  3,  0,  2, 0, 0, 3, 0);
    add(0, 1, 1,  4,  5,  3, 3, 1, 4, 1);
    add(0, 0, 1,  0,  4,  0, 3, 0, 4, 1);
    add(0, 0, 1,  0,  5,  0, 3, 1, 4, 1);
    add(1, 0, 1,  0, 30,  0, 0, 0, 1, 0);
    add(0, 1, 1, 30, 31,  0, 1, 0, 2, 0);

    // Reset state and sweep length
    repeat (2) @(negedge clk);
    check("rst_in_ready",  32'(bus.in_ready), 32'd0);
    check("rst_init_busy", 32'(init_busy), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_node_cnt",  32'(node_cnt), 32'd0);
    check("rst_overflow",  32'(overflow), 32'd0);
    rst_n = 1'b1;
    wait_init("rst_init_len");
    check("init_in_ready", 32'(bus.in_ready), 32'd1);
    check("init_node_cnt", 32'(node_cnt), 32'd0);

    foreach (vecs[i]) begin
      if (vecs[i].clr) do_clear();
      send(vecs[i].s_en, vecs[i].d_en, vecs[i].s, vecs[i].d, 1'b0);
      check($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("v%0d_src_idx", i), 32'(bus.out_src_idx), vecs[i].e_s);
      check($sformatf("v%0d_dst_idx", i), 32'(bus.out_dst_idx), vecs[i].e_d);
      check($sformatf("v%0d_src_en", i), 32'(bus.out_src_en), 32'(vecs[i].s_en));
      check($sformatf("v%0d_dst_en", i), 32'(bus.out_dst_en), 32'(vecs[i].d_en));
      check($sformatf("v%0d_out_ovf", i), 32'(bus.out_overflow), 32'(vecs[i].e_bovf));
      check($sformatf("v%0d_node_cnt", i), 32'(node_cnt), vecs[i].e_cnt);
      check($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vecs[i].e_ovf));
    end

    // Backpressure: first beat stalls in the output register, second waits
    do_clear();
    bus.out_ready = 1'b0;
    send(1'b1, 1'b0, 5, 0, 1'b0);
    bus.in_valid   = 1'b1;
    bus.in_src_str = SW'(9);
    bus.in_last    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready",  32'(bus.in_ready), 32'd0);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_src_idx",   32'(bus.out_src_idx), 32'd0);
      check("bp_out_last",  32'(bus.out_last), 32'd0);
      check("bp_node_cnt",  32'(node_cnt), 32'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check("bp2_out_valid", 32'(bus.out_valid), 32'd1);
    check("bp2_src_idx",   32'(bus.out_src_idx), 32'd1);
    check("bp2_out_last",  32'(bus.out_last), 32'd1);
    check("bp2_node_cnt",  32'(node_cnt), 32'd2);
    @(negedge clk);
    check("done_in_ready", 32'(bus.in_ready), 32'd0);
    check("done_init_busy", 32'(init_busy), 32'd0);
    @(posedge clk);
    #1;
    check("done_drained", 32'(bus.out_valid), 32'd0);

    // Restart after DONE
    do_clear();
    send(1'b1, 1'b0, 5, 0, 1'b0);
    check("restart_src_idx",  32'(bus.out_src_idx), 32'd0);
    check("restart_node_cnt", 32'(node_cnt), 32'd1);
    check("restart_overflow", 32'(overflow), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
